uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with 2-flop rx synchronizer; optional even parity via UART_RX_PARITY_EN
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 rx,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state, state_n;
    logic [TW-1:0]          timer, timer_n;
    logic [BW-1:0]          bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic                   rx_m, rx_s;
    logic                   good, bad;
`ifdef UART_RX_PARITY_EN
    logic                   par_err, par_err_n;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Frame state, bit-timer, bit counter and shift register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
`ifdef UART_RX_PARITY_EN
            par_err <= par_err_n;
`endif
        end
    end

    // Next-state: sample mid-bit, timer restarts at every sample point so no drift accumulates
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        good      = 1'b0;
        bad       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_n = par_err;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    timer_n = '0;
                end
            end
            START: begin
                if (timer == T_HALF) begin
                    timer_n   = '0;
                    bit_cnt_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DATA: begin
                if (timer == T_LAST) begin
                    timer_n   = '0;
                    shift_n   = {rx_s, shift[DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer == T_LAST) begin
                    timer_n   = '0;
                    par_err_n = ^{shift, rx_s};
                    state_n   = STOP;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
`endif
            STOP: begin
                if (timer == T_LAST) begin
                    timer_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_err) bad = 1'b1;
                        else         good = 1'b1;
`else
                        good = 1'b1;
`endif
                    end else begin
                        bad     = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Consumer handshake: load on good frame unless an unacked byte is still held
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data        <= '0;
            valid       <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= bad;
            overrun     <= 1'b0;
            if (good) begin
                if (!valid || ack) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (ack) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx, default parameters
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int LAT     = 156 + PAR_BITS * CPB;
    localparam int LAT_MIN = 154 + PAR_BITS * CPB;
    localparam int LAT_MAX = 157 + PAR_BITS * CPB;

    logic       clk = 1'b0;
    logic       clr;
    logic       rx;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int lat_n    = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = 8'h00;
`ifdef UART_RX_PARITY_EN
    logic       par_flip   = 1'b0;
`endif

    // kind: 0 = data presented, 1 = framing_err pulse, 2 = overrun pulse
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] d;
    } ev_t;
    ev_t sb[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk(clk), .clr(clr), .rx(rx), .ack(ack),
        .data(data), .valid(valid), .framing_err(framing_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [7:0] d);
        sb.push_back({k, d});
    endtask

    task automatic got(input logic [1:0] k, input logic [7:0] d);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected actual kind=%0d data=%0h required none", k, d);
        end else begin
            e = sb.pop_front();
            if (e !== {k, d}) begin
                failures++;
                $display("FAIL sb_event actual kind=%0d data=%0h required kind=%0d data=%0h",
                         k, d, e.kind, e.d);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!clr) begin
                if (valid && (!prev_valid || data !== prev_data)) got(2'd0, data);
                if (framing_err) got(2'd1, data);
                if (overrun)     got(2'd2, data);
            end
            prev_valid = valid;
            prev_data  = data;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip);
`endif
        send_bit(stop_bit);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        idle(1);
    endtask

    initial begin
        clr = 1'b1;
        rx  = 1'b1;
        ack = 1'b0;
        idle(3);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_ferr", framing_err, 0);
        check("rst_ovr", overrun, 0);
        clr = 1'b0;
        idle(5);

        // basic frame and latency window
        expect_ev(2'd0, 8'hA5);
        fork
            send_byte(8'hA5, 1'b1);
            begin
                lat_n = 0;
                while (lat_n < 400 && !valid) begin
                    @(posedge clk);
                    #1;
                    lat_n++;
                end
            end
        join
        check("lat_window", (lat_n >= LAT_MIN && lat_n <= LAT_MAX), 1);
        check("a5_data", data, 8'hA5);
        idle(4);
        pulse_ack();
        check("ack_clears", valid, 0);

        // short start glitch, then a real frame
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(40);
        check("glitch_no_valid", valid, 0);
        expect_ev(2'd0, 8'h3C);
        send_byte(8'h3C, 1'b1);
        idle(4);
        pulse_ack();

        // bad stop bit followed by a long break
        expect_ev(2'd1, 8'h3C);
        send_byte(8'h81, 1'b0);
        rx = 1'b0;
        idle(40 * CPB);
        rx = 1'b1;
        idle(2 * CPB);
        check("break_valid", valid, 0);
        check("break_data", data, 8'h3C);
        expect_ev(2'd0, 8'h12);
        send_byte(8'h12, 1'b1);
        idle(4);
        check("after_break_data", data, 8'h12);
        pulse_ack();

        // back-to-back without ack: overrun keeps first byte
        expect_ev(2'd0, 8'h11);
        expect_ev(2'd2, 8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(4);
        check("ovr_data_kept", data, 8'h11);
        check("ovr_valid", valid, 1);
        pulse_ack();

        // back-to-back with ack on the completing cycle of the second frame
        expect_ev(2'd0, 8'h11);
        expect_ev(2'd0, 8'h22);
        send_byte(8'h11, 1'b1);
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                ack = 1'b1;
                @(posedge clk);
                #1;
                ack = 1'b0;
            end
        join
        idle(4);
        check("ack_coinc_valid", valid, 1);
        check("ack_coinc_data", data, 8'h22);

        // clr during the 4th data bit while a byte is still held
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (70) @(posedge clk);
                #1;
                clr = 1'b1;
                #1;
                check("clr_data", data, 0);
                check("clr_valid", valid, 0);
                check("clr_ferr", framing_err, 0);
                check("clr_ovr", overrun, 0);
                idle(2);
                clr = 1'b0;
            end
        join
        idle(2 * CPB);
        check("clr_no_valid", valid, 0);
        expect_ev(2'd0, 8'h5A);
        send_byte(8'h5A, 1'b1);
        idle(4);
        check("after_clr_data", data, 8'h5A);
        pulse_ack();

`ifdef UART_RX_PARITY_EN
        expect_ev(2'd0, 8'h07);
        send_byte(8'h07, 1'b1);
        idle(4);
        check("par_good_data", data, 8'h07);
        pulse_ack();
        expect_ev(2'd1, 8'h07);
        par_flip = 1'b1;
        send_byte(8'h07, 1'b1);
        par_flip = 1'b0;
        idle(4);
        check("par_bad_valid", valid, 0);
`endif

        idle(10);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
